// File: rtl/sys_cmd_pkg.sv
// Shared command codes, operand addresses and FSM state encoding for the command controller.
package sys_cmd_pkg;

  localparam logic [7:0] CMD_RF_WR  = 8'hAA;
  localparam logic [7:0] CMD_RF_RD  = 8'hBB;
  localparam logic [7:0] CMD_ALU_WP = 8'hCC;
  localparam logic [7:0] CMD_ALU_NP = 8'hDD;

  localparam int OPA_ADDR = 0;
  localparam int OPB_ADDR = 1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_ADDR,
    ST_WR_DATA,
    ST_RD_ADDR,
    ST_RD_WAIT,
    ST_TX_RD,
    ST_OPA,
    ST_OPB,
    ST_FUN,
    ST_ALU_WAIT,
    ST_TX_LO,
    ST_TX_HI
  } state_t;

endpackage

// File: rtl/sys_cmd_tx_mux.sv
// Selects the response byte for the current transmit state and decides whether it may be pushed now.
module sys_cmd_tx_mux
  import sys_cmd_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int ALU_OUT_WIDTH = 16
) (
  input  state_t                   state,
  input  logic [DATA_WIDTH-1:0]    rd_data,
  input  logic [ALU_OUT_WIDTH-1:0] alu_result,
  input  logic                     fifo_full,
  output logic                     push,
  output logic [DATA_WIDTH-1:0]    push_data
);

  always_comb begin
    push      = 1'b0;
    push_data = rd_data;
    case (state)
      ST_TX_RD: begin
        push      = !fifo_full;
        push_data = rd_data;
      end
      ST_TX_LO: begin
        push      = !fifo_full;
        push_data = alu_result[DATA_WIDTH-1:0];
      end
      ST_TX_HI: begin
        push      = !fifo_full;
        push_data = alu_result[ALU_OUT_WIDTH-1:DATA_WIDTH];
      end
      default: begin
        push      = 1'b0;
        push_data = rd_data;
      end
    endcase
  end

endmodule

// File: rtl/sys_cmd_ctrl.sv
// Frame decoder/sequencer: turns RX command bytes into regfile and ALU operations and
// queues read data / ALU results into the TX FIFO. Every output comes straight from a flop.
module sys_cmd_ctrl
  import sys_cmd_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 4,
  parameter int ALU_FUN_WIDTH = 4,
  parameter int ALU_OUT_WIDTH = 16
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic [DATA_WIDTH-1:0]    RX_P_DATA,
  input  logic                     RX_D_VLD,
  output logic                     RF_WR_EN,
  output logic                     RF_RD_EN,
  output logic [ADDR_WIDTH-1:0]    RF_ADDR,
  output logic [DATA_WIDTH-1:0]    RF_WR_DATA,
  input  logic [DATA_WIDTH-1:0]    RF_RD_DATA,
  input  logic                     RF_RD_VLD,
  output logic                     ALU_EN,
  output logic [ALU_FUN_WIDTH-1:0] ALU_FUN,
  input  logic [ALU_OUT_WIDTH-1:0] ALU_OUT,
  input  logic                     ALU_OUT_VLD,
  output logic                     CLK_GATE_EN,
  output logic [DATA_WIDTH-1:0]    FIFO_WR_DATA,
  output logic                     FIFO_WR_INC,
  input  logic                     FIFO_FULL
);

  state_t                   state_reg, state_next;
  logic [ADDR_WIDTH-1:0]    wr_addr_reg, wr_addr_next;
  logic [DATA_WIDTH-1:0]    rd_data_reg, rd_data_next;
  logic [ALU_OUT_WIDTH-1:0] alu_result_reg, alu_result_next;

  logic                     rf_wr_en_reg, rf_wr_en_next;
  logic                     rf_rd_en_reg, rf_rd_en_next;
  logic [ADDR_WIDTH-1:0]    rf_addr_reg, rf_addr_next;
  logic [DATA_WIDTH-1:0]    rf_wr_data_reg, rf_wr_data_next;
  logic                     alu_en_reg, alu_en_next;
  logic [ALU_FUN_WIDTH-1:0] alu_fun_reg, alu_fun_next;
  logic                     clk_gate_en_reg, clk_gate_en_next;
  logic [DATA_WIDTH-1:0]    fifo_wr_data_reg, fifo_wr_data_next;
  logic                     fifo_wr_inc_reg, fifo_wr_inc_next;

  logic                     tx_push;
  logic [DATA_WIDTH-1:0]    tx_data;

  sys_cmd_tx_mux #(
    .DATA_WIDTH   (DATA_WIDTH),
    .ALU_OUT_WIDTH(ALU_OUT_WIDTH)
  ) u_tx_mux (
    .state     (state_reg),
    .rd_data   (rd_data_reg),
    .alu_result(alu_result_reg),
    .fifo_full (FIFO_FULL),
    .push      (tx_push),
    .push_data (tx_data)
  );

  always_comb begin
    state_next        = state_reg;
    wr_addr_next      = wr_addr_reg;
    rd_data_next      = rd_data_reg;
    alu_result_next   = alu_result_reg;
    rf_wr_en_next     = 1'b0;
    rf_rd_en_next     = 1'b0;
    rf_addr_next      = rf_addr_reg;
    rf_wr_data_next   = rf_wr_data_reg;
    alu_en_next       = 1'b0;
    alu_fun_next      = alu_fun_reg;
    fifo_wr_inc_next  = tx_push;
    fifo_wr_data_next = tx_push ? tx_data : fifo_wr_data_reg;

    case (state_reg)
      ST_IDLE: begin
        if (RX_D_VLD) begin
          if (RX_P_DATA == DATA_WIDTH'(CMD_RF_WR))       state_next = ST_WR_ADDR;
          else if (RX_P_DATA == DATA_WIDTH'(CMD_RF_RD))  state_next = ST_RD_ADDR;
          else if (RX_P_DATA == DATA_WIDTH'(CMD_ALU_WP)) state_next = ST_OPA;
          else if (RX_P_DATA == DATA_WIDTH'(CMD_ALU_NP)) state_next = ST_FUN;
        end
      end
      ST_WR_ADDR: begin
        if (RX_D_VLD) begin
          wr_addr_next = RX_P_DATA[ADDR_WIDTH-1:0];
          state_next   = ST_WR_DATA;
        end
      end
      ST_WR_DATA: begin
        if (RX_D_VLD) begin
          rf_wr_en_next   = 1'b1;
          rf_addr_next    = wr_addr_reg;
          rf_wr_data_next = RX_P_DATA;
          state_next      = ST_IDLE;
        end
      end
      ST_RD_ADDR: begin
        if (RX_D_VLD) begin
          rf_rd_en_next = 1'b1;
          rf_addr_next  = RX_P_DATA[ADDR_WIDTH-1:0];
          state_next    = ST_RD_WAIT;
        end
      end
      // Wait states never look at RX, so a byte colliding with a result strobe is simply lost.
      ST_RD_WAIT: begin
        if (RF_RD_VLD) begin
          rd_data_next = RF_RD_DATA;
          state_next   = ST_TX_RD;
        end
      end
      ST_TX_RD: begin
        if (tx_push) state_next = ST_IDLE;
      end
      ST_OPA: begin
        if (RX_D_VLD) begin
          rf_wr_en_next   = 1'b1;
          rf_addr_next    = ADDR_WIDTH'(OPA_ADDR);
          rf_wr_data_next = RX_P_DATA;
          state_next      = ST_OPB;
        end
      end
      ST_OPB: begin
        if (RX_D_VLD) begin
          rf_wr_en_next   = 1'b1;
          rf_addr_next    = ADDR_WIDTH'(OPB_ADDR);
          rf_wr_data_next = RX_P_DATA;
          state_next      = ST_FUN;
        end
      end
      ST_FUN: begin
        if (RX_D_VLD) begin
          alu_en_next  = 1'b1;
          alu_fun_next = RX_P_DATA[ALU_FUN_WIDTH-1:0];
          state_next   = ST_ALU_WAIT;
        end
      end
      ST_ALU_WAIT: begin
        if (ALU_OUT_VLD) begin
          alu_result_next = ALU_OUT;
          state_next      = ST_TX_LO;
        end
      end
      ST_TX_LO: begin
        if (tx_push) state_next = ST_TX_HI;
      end
      ST_TX_HI: begin
        if (tx_push) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase

    // Derived from the next state so the registered gate lines up exactly with FUN/ALU_WAIT.
    clk_gate_en_next = (state_next == ST_FUN) || (state_next == ST_ALU_WAIT);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg        <= ST_IDLE;
      wr_addr_reg      <= '0;
      rd_data_reg      <= '0;
      alu_result_reg   <= '0;
      rf_wr_en_reg     <= 1'b0;
      rf_rd_en_reg     <= 1'b0;
      rf_addr_reg      <= '0;
      rf_wr_data_reg   <= '0;
      alu_en_reg       <= 1'b0;
      alu_fun_reg      <= '0;
      clk_gate_en_reg  <= 1'b0;
      fifo_wr_data_reg <= '0;
      fifo_wr_inc_reg  <= 1'b0;
    end else begin
      state_reg        <= state_next;
      wr_addr_reg      <= wr_addr_next;
      rd_data_reg      <= rd_data_next;
      alu_result_reg   <= alu_result_next;
      rf_wr_en_reg     <= rf_wr_en_next;
      rf_rd_en_reg     <= rf_rd_en_next;
      rf_addr_reg      <= rf_addr_next;
      rf_wr_data_reg   <= rf_wr_data_next;
      alu_en_reg       <= alu_en_next;
      alu_fun_reg      <= alu_fun_next;
      clk_gate_en_reg  <= clk_gate_en_next;
      fifo_wr_data_reg <= fifo_wr_data_next;
      fifo_wr_inc_reg  <= fifo_wr_inc_next;
    end
  end

  assign RF_WR_EN     = rf_wr_en_reg;
  assign RF_RD_EN     = rf_rd_en_reg;
  assign RF_ADDR      = rf_addr_reg;
  assign RF_WR_DATA   = rf_wr_data_reg;
  assign ALU_EN       = alu_en_reg;
  assign ALU_FUN      = alu_fun_reg;
  assign CLK_GATE_EN  = clk_gate_en_reg;
  assign FIFO_WR_DATA = fifo_wr_data_reg;
  assign FIFO_WR_INC  = fifo_wr_inc_reg;

endmodule
